// File: rtl/johnson_decoder_if.sv
// Sample/result bundle between a Johnson-code source and the decoder.
// The source drives the master side; the decoder drives the slave side's outputs.
interface johnson_decoder_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0]   cnt_in;
    logic               cnt_vld;
    logic [IW-1:0]      idx;
    logic [2*WIDTH-1:0] onehot;
    logic               idx_vld;
    logic               code_err;
    logic               seq_err;
    logic               locked;
    logic [7:0]         err_cnt;

    modport master (
        output cnt_in, cnt_vld,
        input  idx, onehot, idx_vld, code_err, seq_err, locked, err_cnt
    );

    modport slave (
        input  cnt_in, cnt_vld,
        output idx, onehot, idx_vld, code_err, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson-code decoder and sequence-integrity monitor with HUNT/LOCKED acquisition.
// Latency 1 cycle (all outputs registered); no back-pressure, one sample accepted per cycle.
module johnson_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_N     = 3,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              load,
    johnson_decoder_if.slave  bus
);
    localparam int            N        = 2 * WIDTH;
    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [3:0]    LOCK_RUN = 4'(LOCK_N);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            has_prev_q, has_prev_d;
    logic [IW-1:0]   prev_q, prev_d;
    logic [3:0]      run_q, run_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    onehot_q, onehot_d;
    logic            idx_vld_q, idx_vld_d;
    logic            code_err_q, code_err_d;
    logic            seq_err_q, seq_err_d;
    logic            locked_q, locked_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            legal;
    logic [IW-1:0]   dec_idx;
    logic [IW-1:0]   next_prev;
    logic            is_succ;
    logic            is_hold;

    // A legal Johnson word has at most one boundary between its run of ones and zeros.
    always_comb begin
        int trans;
        int ones;
        trans = 0;
        ones  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(bus.cnt_in[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans = trans + int'(bus.cnt_in[i] ^ bus.cnt_in[i+1]);
        end
        legal     = (trans <= 1);
        dec_idx   = bus.cnt_in[WIDTH-1] ? IW'(N - ones) : IW'(ones);
        next_prev = (prev_q == LAST) ? '0 : prev_q + 1'b1;
        is_succ   = has_prev_q && (dec_idx == next_prev);
        is_hold   = has_prev_q && (dec_idx == prev_q);
    end

    always_comb begin
        state_d    = state_q;
        has_prev_d = has_prev_q;
        prev_d     = prev_q;
        run_d      = run_q;
        idx_d      = idx_q;
        onehot_d   = '0;
        idx_vld_d  = 1'b0;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (bus.cnt_vld) begin
            if (!legal) begin
                code_err_d = 1'b1;
                has_prev_d = 1'b0;
                run_d      = '0;
                state_d    = HUNT;
            end else begin
                idx_d     = dec_idx;
                onehot_d  = ONE << dec_idx;
                idx_vld_d = 1'b1;
                unique case (state_q)
                    HUNT: begin
                        if (!has_prev_q) begin
                            prev_d     = dec_idx;
                            has_prev_d = 1'b1;
                            run_d      = '0;
                        end else if (is_succ) begin
                            prev_d = dec_idx;
                            if (run_q + 4'd1 == LOCK_RUN) begin
                                state_d = LOCKED;
                                run_d   = '0;
                            end else begin
                                run_d = run_q + 4'd1;
                            end
                        end else if (!(is_hold && ALLOW_HOLD)) begin
                            prev_d = dec_idx;
                            run_d  = '0;
                        end
                    end
                    LOCKED: begin
                        if (is_succ) begin
                            prev_d = dec_idx;
                        end else if (!(is_hold && ALLOW_HOLD)) begin
                            // Re-seed from the offending code so re-acquisition starts here.
                            seq_err_d = 1'b1;
                            prev_d    = dec_idx;
                            run_d     = '0;
                            state_d   = HUNT;
                        end
                    end
                endcase
            end

            if ((code_err_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (load) begin
            state_q    <= HUNT;
            has_prev_q <= 1'b0;
            prev_q     <= '0;
            run_q      <= '0;
            idx_q      <= '0;
            onehot_q   <= '0;
            idx_vld_q  <= 1'b0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            has_prev_q <= has_prev_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            idx_q      <= idx_d;
            onehot_q   <= onehot_d;
            idx_vld_q  <= idx_vld_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.idx      = idx_q;
    assign bus.onehot   = onehot_q;
    assign bus.idx_vld  = idx_vld_q;
    assign bus.code_err = code_err_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.locked   = locked_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Drives identical streams into a hold-tolerant and a hold-intolerant decoder and
// compares both against a table-lookup reference model.
module tb_johnson_decoder;
    localparam int W  = 4;
    localparam int N  = 2 * W;
    localparam int LN = 3;

    logic clk = 1'b0;
    logic load;
    always #5 clk = ~clk;

    johnson_decoder_if #(.WIDTH(W)) bus_h ();
    johnson_decoder_if #(.WIDTH(W)) bus_n ();

    johnson_decoder #(.WIDTH(W), .LOCK_N(LN), .ALLOW_HOLD(1'b1)) dut_h (
        .clk (clk),
        .load(load),
        .bus (bus_h)
    );

    johnson_decoder #(.WIDTH(W), .LOCK_N(LN), .ALLOW_HOLD(1'b0)) dut_n (
        .clk (clk),
        .load(load),
        .bus (bus_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] code_tab [N];

    bit m_has  [2];
    int m_prev [2];
    int m_run  [2];
    bit m_lock [2];
    int m_err  [2];
    int e_idx  [2];
    int e_oh   [2];
    bit e_vld  [2];
    bit e_cerr [2];
    bit e_serr [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int lookup(input logic [W-1:0] c);
        int k;
        k = -1;
        for (int i = 0; i < N; i++) begin
            if (code_tab[i] == c) k = i;
        end
        return k;
    endfunction

    task automatic model(input int m, input bit ah, input bit ld, input bit vld,
                         input logic [W-1:0] c);
        int  k;
        bit  succ;
        bit  hold;
        e_vld[m]  = 1'b0;
        e_cerr[m] = 1'b0;
        e_serr[m] = 1'b0;
        e_oh[m]   = 0;
        if (ld) begin
            m_has[m]  = 1'b0;
            m_prev[m] = 0;
            m_run[m]  = 0;
            m_lock[m] = 1'b0;
            m_err[m]  = 0;
            e_idx[m]  = 0;
        end else if (vld) begin
            k = lookup(c);
            if (k < 0) begin
                e_cerr[m] = 1'b1;
                m_has[m]  = 1'b0;
                m_run[m]  = 0;
                m_lock[m] = 1'b0;
            end else begin
                e_idx[m] = k;
                e_oh[m]  = 1 << k;
                e_vld[m] = 1'b1;
                succ = m_has[m] && (k == (m_prev[m] + 1) % N);
                hold = m_has[m] && (k == m_prev[m]);
                if (m_lock[m]) begin
                    if (succ) m_prev[m] = k;
                    else if (!(hold && ah)) begin
                        e_serr[m] = 1'b1;
                        m_prev[m] = k;
                        m_run[m]  = 0;
                        m_lock[m] = 1'b0;
                    end
                end else if (!m_has[m]) begin
                    m_has[m]  = 1'b1;
                    m_prev[m] = k;
                    m_run[m]  = 0;
                end else if (succ) begin
                    m_prev[m] = k;
                    m_run[m]++;
                    if (m_run[m] == LN) begin
                        m_lock[m] = 1'b1;
                        m_run[m]  = 0;
                    end
                end else if (!(hold && ah)) begin
                    m_prev[m] = k;
                    m_run[m]  = 0;
                end
            end
            if ((e_cerr[m] || e_serr[m]) && m_err[m] < 255) m_err[m]++;
        end
    endtask

    task automatic cmp_dut(input string nm, input int m, input logic [31:0] idx,
                           input logic [31:0] oh, input logic [31:0] iv,
                           input logic [31:0] ce, input logic [31:0] se,
                           input logic [31:0] lk, input logic [31:0] ec);
        chk({nm, "_idx"},      idx, 32'(e_idx[m]));
        chk({nm, "_onehot"},   oh,  32'(e_oh[m]));
        chk({nm, "_idx_vld"},  iv,  32'(e_vld[m]));
        chk({nm, "_code_err"}, ce,  32'(e_cerr[m]));
        chk({nm, "_seq_err"},  se,  32'(e_serr[m]));
        chk({nm, "_locked"},   lk,  32'(m_lock[m]));
        chk({nm, "_err_cnt"},  ec,  32'(m_err[m]));
    endtask

    task automatic step(input bit ld, input bit vld, input logic [W-1:0] c);
        load          = ld;
        bus_h.cnt_vld = vld;
        bus_h.cnt_in  = c;
        bus_n.cnt_vld = vld;
        bus_n.cnt_in  = c;
        model(0, 1'b1, ld, vld, c);
        model(1, 1'b0, ld, vld, c);
        @(posedge clk);
        #1;
        cmp_dut("hold", 0, 32'(bus_h.idx), 32'(bus_h.onehot), 32'(bus_h.idx_vld),
                32'(bus_h.code_err), 32'(bus_h.seq_err), 32'(bus_h.locked), 32'(bus_h.err_cnt));
        cmp_dut("nohold", 1, 32'(bus_n.idx), 32'(bus_n.onehot), 32'(bus_n.idx_vld),
                32'(bus_n.code_err), 32'(bus_n.seq_err), 32'(bus_n.locked), 32'(bus_n.err_cnt));
    endtask

    task automatic feed(input logic [W-1:0] c);
        step(1'b0, 1'b1, c);
    endtask

    initial begin
        int           cur;
        int           r;
        int           k;
        logic [W-1:0] rc;

        for (int i = 0; i < N; i++) begin
            if (i <= W) code_tab[i] = W'((1 << i) - 1);
            else        code_tab[i] = W'(((1 << W) - 1) & ~((1 << (i - W)) - 1));
        end

        load = 1'b1;
        bus_h.cnt_vld = 1'b0;
        bus_h.cnt_in  = '0;
        bus_n.cnt_vld = 1'b0;
        bus_n.cnt_in  = '0;

        step(1'b1, 1'b0, 4'b0000);
        chk("reset_err_cnt", 32'(bus_h.err_cnt), 32'd0);

        // Acquisition: seed plus three successor steps.
        feed(4'b0000); feed(4'b0001); feed(4'b0011); feed(4'b0111);
        chk("acq_locked", 32'(bus_h.locked), 32'd1);
        chk("acq_idx", 32'(bus_h.idx), 32'd3);

        // Locked stream through the wrap.
        feed(4'b1111); feed(4'b1110); feed(4'b1100); feed(4'b1000);
        feed(4'b0000); feed(4'b0001);

        // Illegal code, then four legal codes to relock.
        feed(4'b0110);
        chk("cerr_idx_hold", 32'(bus_h.idx), 32'd1);
        chk("cerr_unlocked", 32'(bus_n.locked), 32'd0);
        feed(4'b0001); feed(4'b0011); feed(4'b0111); feed(4'b1111);
        chk("relock_after_cerr", 32'(bus_h.locked), 32'd1);

        // Walk to idx 2, then jump to idx 4.
        feed(4'b1110); feed(4'b1100); feed(4'b1000); feed(4'b0000);
        feed(4'b0001); feed(4'b0011);
        feed(4'b1111);
        chk("serr_pulse", 32'(bus_h.seq_err), 32'd1);
        chk("serr_idx", 32'(bus_h.idx), 32'd4);
        feed(4'b1110); feed(4'b1100); feed(4'b1000);
        chk("relock_after_serr", 32'(bus_h.locked), 32'd1);

        // Holds at idx 2.
        feed(4'b0000); feed(4'b0001); feed(4'b0011);
        feed(4'b0011);
        chk("nohold_first_repeat", 32'(bus_n.seq_err), 32'd1);
        feed(4'b0011); feed(4'b0011);
        chk("hold_stays_locked", 32'(bus_h.locked), 32'd1);

        // Randomized mix of successors, holds, random words, idle cycles and loads.
        cur = 2;
        for (int n = 0; n < 2000; n++) begin
            r  = int'($urandom_range(99));
            rc = W'($urandom);
            if (r < 2) begin
                step(1'b1, 1'b1, code_tab[cur]);
            end else if (r < 10) begin
                step(1'b0, 1'b0, rc);
            end else if (r < 20) begin
                feed(rc);
                k = lookup(rc);
                if (k >= 0) cur = k;
            end else if (r < 30) begin
                feed(code_tab[cur]);
            end else begin
                cur = (cur + 1) % N;
                feed(code_tab[cur]);
            end
        end

        // Saturation, then load with a legal sample present.
        repeat (300) feed(4'b0110);
        chk("sat_hold", 32'(bus_h.err_cnt), 32'd255);
        chk("sat_nohold", 32'(bus_n.err_cnt), 32'd255);
        step(1'b1, 1'b1, 4'b0001);
        chk("load_err_cnt", 32'(bus_h.err_cnt), 32'd0);
        chk("load_idx_vld", 32'(bus_h.idx_vld), 32'd0);
        feed(4'b0011);
        chk("post_load_seed", 32'(bus_h.idx), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
